// File: rtl/button_debouncer_pkg.sv
// Shared state encoding and decode helpers for the button debouncer.
// The include guard lets this file be pulled in by several compilation units.
`ifndef BUTTON_DEBOUNCER_PKG_SV
`define BUTTON_DEBOUNCER_PKG_SV

package button_debouncer_pkg;

    // Bit 1 of the encoding is the debounced level; bit 0 marks the stable states' neighbours.
    typedef enum logic [1:0] {
        DB_STABLE_LO = 2'b00,
        DB_PEND_HI   = 2'b01,
        DB_STABLE_HI = 2'b11,
        DB_PEND_LO   = 2'b10
    } db_state_e;

    function automatic logic db_is_pending(input db_state_e s);
        return (s == DB_PEND_HI) || (s == DB_PEND_LO);
    endfunction

    function automatic logic db_level(input db_state_e s);
        return (s == DB_STABLE_HI) || (s == DB_PEND_LO);
    endfunction

endpackage

`endif

// File: rtl/button_debouncer_cell.sv
// One debounce channel: synchroniser chain, 4-state debounce FSM and stability counter.
// Optional auto-repeat gaps while held high are enabled with `define AUTOREPEAT_EN.
module button_debouncer_cell
    import button_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 20,
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_DELAY  = 1000000,
    parameter int REPEAT_PERIOD = 250000
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      raw,
    output logic      level,
    output db_state_e state
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2
        || STABLE_CYCLES > (2 ** CNT_W) - 1) begin : g_cfg_err
        $error("button_debouncer_cell: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    assign s = sync_q[SYNC_STAGES-1];

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             gap_q, gap_d;
    logic             rep_phase_q, rep_phase_d;
`endif

    // State register, counters and synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= DB_STABLE_LO;
            cnt_q   <= '0;
`ifdef AUTOREPEAT_EN
            rcnt_q      <= '0;
            gap_q       <= 1'b0;
            rep_phase_q <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef AUTOREPEAT_EN
            rcnt_q      <= rcnt_d;
            gap_q       <= gap_d;
            rep_phase_q <= rep_phase_d;
`endif
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            DB_STABLE_LO: begin
                if (s) begin
                    state_d = DB_PEND_HI;
                    cnt_d   = '0;
                end
            end
            DB_PEND_HI: begin
                if (!s) begin
                    state_d = DB_STABLE_LO;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = DB_STABLE_HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DB_STABLE_HI: begin
                if (!s) begin
                    state_d = DB_PEND_LO;
                    cnt_d   = '0;
                end
            end
            DB_PEND_LO: begin
                if (s) begin
                    state_d = DB_STABLE_HI;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = DB_STABLE_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DB_STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef AUTOREPEAT_EN
    // Repeat counter only runs while the channel stays in STABLE_HI; the first
    // interval is REPEAT_DELAY, every later one REPEAT_PERIOD.
    always_comb begin
        rcnt_d      = '0;
        gap_d       = 1'b0;
        rep_phase_d = 1'b0;
        if (state_q == DB_STABLE_HI && state_d == DB_STABLE_HI) begin
            rep_phase_d = rep_phase_q;
            if (rcnt_q == (rep_phase_q ? PERIOD_LAST : DELAY_LAST)) begin
                gap_d       = 1'b1;
                rep_phase_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end
`endif

    // Outputs decode registered state only.
    always_comb begin
        state = state_q;
`ifdef AUTOREPEAT_EN
        level = db_level(state_q) & ~gap_q;
`else
        level = db_level(state_q);
`endif
    end

endmodule

// File: rtl/button_debouncer.sv
// WIDTH independent push-button debouncers with a shared busy flag.
// Auto-repeat while held is enabled by `define AUTOREPEAT_EN.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 20,
    parameter int STABLE_CYCLES = 500000,
    parameter int REPEAT_DELAY  = 1000000,
    parameter int REPEAT_PERIOD = 250000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    db_state_e        cell_state [WIDTH];
    logic [WIDTH-1:0] pend;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        button_debouncer_cell #(
            .SYNC_STAGES  (SYNC_STAGES),
            .CNT_W        (CNT_W),
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .raw  (in[i]),
            .level(out[i]),
            .state(cell_state[i])
        );

        assign pend[i] = db_is_pending(cell_state[i]);
    end

    // Every pend bit is a decode of a state flop, so busy carries no path from in.
    assign busy = |pend;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: SYNC_STAGES=2, STABLE_CYCLES=4 -> 7-edge latency.
module tb_button_debouncer;

    localparam int WIDTH = 4;
`ifdef AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in  = '0;
    logic [WIDTH-1:0] out;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    button_debouncer #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (2),
        .CNT_W        (4),
        .STABLE_CYCLES(4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one active edge; everything after this is away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] exp_o;
        logic             exp_b;
        rst = 1'b1;
        in  = 4'hF;
        step();
        step();
        vectors++;
        if (out !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_out got=%b exp=%b", out, 4'h0);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got=%b exp=%b", busy, 1'b0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_o = (k >= 7) ? 4'hF : 4'h0;
            exp_b = (k >= 3 && k <= 6);
            vectors++;
            if (out !== exp_o) begin
                miscompares++;
                $display("FAIL reset_rise k=%0d got=%b exp=%b", k, out, exp_o);
            end
            vectors++;
            if (busy !== exp_b) begin
                miscompares++;
                $display("FAIL reset_rise_busy k=%0d got=%b exp=%b", k, busy, exp_b);
            end
        end
        in = 4'h0;
        for (int k = 1; k <= 8; k++) step();
        vectors++;
        if (out !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_release got=%b exp=%b", out, 4'h0);
        end
    endtask

    task automatic test_clean_press();
        logic [WIDTH-1:0] exp_o;
        logic             exp_b;
        in = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_o = (k >= 7) ? 4'b0001 : 4'b0000;
            exp_b = (k >= 3 && k <= 6);
            vectors++;
            if (out !== exp_o) begin
                miscompares++;
                $display("FAIL press_out k=%0d got=%b exp=%b", k, out, exp_o);
            end
            vectors++;
            if (busy !== exp_b) begin
                miscompares++;
                $display("FAIL press_busy k=%0d got=%b exp=%b", k, busy, exp_b);
            end
        end
        in = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_o = (k >= 7) ? 4'b0000 : 4'b0001;
            exp_b = (k >= 3 && k <= 6);
            vectors++;
            if (out !== exp_o) begin
                miscompares++;
                $display("FAIL release_out k=%0d got=%b exp=%b", k, out, exp_o);
            end
            vectors++;
            if (busy !== exp_b) begin
                miscompares++;
                $display("FAIL release_busy k=%0d got=%b exp=%b", k, busy, exp_b);
            end
        end
    endtask

    task automatic test_glitch();
        logic [WIDTH-1:0] exp_o;
        // 3-sample pulse: rejected.
        in = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 3) in = 4'b0000;
            vectors++;
            if (out !== 4'b0000) begin
                miscompares++;
                $display("FAIL glitch_out k=%0d got=%b exp=%b", k, out, 4'b0000);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_busy got=%b exp=%b", busy, 1'b0);
        end
        // Pulse covering the whole pending window: accepted, then released.
        in = 4'b0001;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 5) in = 4'b0000;
            exp_o = (k >= 7 && k <= 11) ? 4'b0001 : 4'b0000;
            vectors++;
            if (out !== exp_o) begin
                miscompares++;
                $display("FAIL hold_out k=%0d got=%b exp=%b", k, out, exp_o);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_busy got=%b exp=%b", busy, 1'b0);
        end
    endtask

    task automatic test_bounce();
        logic [4:0]       pat;
        logic [WIDTH-1:0] exp_o;
        pat = 5'b10101;
        in  = {3'b000, pat[0]};
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k < 5) in = {3'b000, pat[k]};
            exp_o = (k >= 11) ? 4'b0001 : 4'b0000;
            vectors++;
            if (out !== exp_o) begin
                miscompares++;
                $display("FAIL bounce_out k=%0d got=%b exp=%b", k, out, exp_o);
            end
        end
        in = 4'b0000;
        for (int k = 1; k <= 8; k++) step();
        vectors++;
        if (out !== 4'b0000) begin
            miscompares++;
            $display("FAIL bounce_release got=%b exp=%b", out, 4'b0000);
        end
    endtask

    task automatic test_multi_channel();
        logic [WIDTH-1:0] exp_o;
        in = 4'b0101;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_o = (k >= 7) ? 4'b0101 : 4'b0000;
            vectors++;
            if (out !== exp_o) begin
                miscompares++;
                $display("FAIL multi_a k=%0d got=%b exp=%b", k, out, exp_o);
            end
        end
        in = 4'b1010;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_o = (k >= 7) ? 4'b1010 : 4'b0101;
            vectors++;
            if (out !== exp_o) begin
                miscompares++;
                $display("FAIL multi_b k=%0d got=%b exp=%b", k, out, exp_o);
            end
        end
        in = 4'b0000;
        for (int k = 1; k <= 8; k++) step();
        vectors++;
        if (out !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL multi_idle got=%b/%b exp=%b/%b", out, busy, 4'b0000, 1'b0);
        end
    endtask

    task automatic test_autorepeat();
        logic exp_l;
        in = 4'b0001;
        for (int k = 1; k <= 33; k++) begin
            step();
            if (k == 26) in = 4'b0000;
            // 10 high cycles after entering STABLE_HI, then a gap every 3 edges;
            // release reaches the FSM at edge 29, so no gap there and the fall lands on 33.
            if (k < 7 || k >= 33)
                exp_l = 1'b0;
            else if (AR && k >= 17 && k <= 26 && ((k - 17) % 3 == 0))
                exp_l = 1'b0;
            else
                exp_l = 1'b1;
            vectors++;
            if (out !== {3'b000, exp_l}) begin
                miscompares++;
                $display("FAIL repeat_out k=%0d got=%b exp=%b", k, out, {3'b000, exp_l});
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [WIDTH-1:0] exp_o;
        in = 4'b0010;
        for (int k = 1; k <= 4; k++) step();
        rst = 1'b1;
        step();
        vectors++;
        if (out !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_abort got=%b/%b exp=%b/%b", out, busy, 4'b0000, 1'b0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_o = (k >= 7) ? 4'b0010 : 4'b0000;
            vectors++;
            if (out !== exp_o) begin
                miscompares++;
                $display("FAIL midrst_rise k=%0d got=%b exp=%b", k, out, exp_o);
            end
        end
        in = 4'b0000;
        for (int k = 1; k <= 8; k++) step();
        vectors++;
        if (out !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_release got=%b exp=%b", out, 4'b0000);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_multi_channel();
        test_autorepeat();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
